// File: rtl/serial_frame_ctrl.sv
// Receive sequencer for the serial input link: start-nibble hunt,
// payload capture, stop-bit check and valid/ready word delivery.
module serial_frame_ctrl #(
  parameter int DATA_W    = 8,
  parameter int START_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sIn,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int ZW = $clog2(START_LEN);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ZW-1:0] ZLAST = ZW'(START_LEN - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ZW-1:0]     zcnt_q, zcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              ovr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARM;
      zcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_set = 1'b0;
    if (valid_q && data_ready) valid_d = 1'b0;
    unique case (state_q)
      ARM: begin
        if (sIn) state_d = HUNT;
      end
      HUNT: begin
        if (sIn) begin
          zcnt_d = '0;
        end else if (zcnt_q == ZLAST) begin
          state_d = DATA;
          zcnt_d  = '0;
          bcnt_d  = '0;
        end else begin
          zcnt_d = zcnt_q + 1'b1;
        end
      end
      DATA: begin
        shreg_d = DATA_W'({shreg_q, sIn});
        bcnt_d  = bcnt_q + 1'b1;
        if (bcnt_q == BLAST) begin
          state_d = STOP;
          bcnt_d  = '0;
        end
      end
      STOP: begin
        if (sIn) begin
          // The good stop bit doubles as the idle 1 that re-arms the hunt
          state_d = HUNT;
          if (!valid_q || data_ready) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end else begin
          state_d = ARM;
          ferr_d  = 1'b1;
        end
      end
    endcase
    ovr_d = ovr_set | (ovr_q & ~clr_ovr);
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = ((state_q == HUNT) && (zcnt_q != '0))
                    || (state_q == DATA) || (state_q == STOP);

endmodule
